operand_loader: RTL and testbench

- Upstream stage of the generated datapath top.
- Accepts a valid/ready word stream and assembles NUM_OPS operands into a parallel operand bus.
- Pulses start to launch the datapath FSM, then holds the operands stable until the datapath signals done.
- Reports framing errors and counts issued frames.

---
 rtl/operand_loader.sv | 149 ++++++++++++++
 tb/tb_operand_loader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/operand_loader.sv
// ---------------------------------------------------------------------------
// operand_loader
//
// Purpose:
//   Upstream stage of the datapath. Collects NUM_OPS words from a valid/ready
//   stream into a parallel operand bus, pulses o_start for one cycle to launch
//   the datapath, then holds the operands (and stalls the stream) until the
//   datapath reports i_done. Framing violations set a sticky error flag, and
//   every issued frame is counted.
//
// Ports:
//   i_clk       clock, all logic on the rising edge
//   i_rst_n     asynchronous, active-low reset
//   i_s_data    input stream word (WIDTH)
//   i_s_valid   i_s_data is valid
//   i_s_last    marks the final word of a frame
//   o_s_ready   loader accepts a word this cycle (registered, state only)
//   o_op_bus    operand k at bits [k*WIDTH +: WIDTH]
//   o_start     one-cycle launch pulse to the datapath
//   i_done      datapath finished the current frame (level or pulse)
//   o_err       sticky framing error (short or long frame)
//   o_frames    number of frames issued, wraps at 2**CNT_W
// ---------------------------------------------------------------------------
module operand_loader #(
    parameter int WIDTH   = 32,
    parameter int NUM_OPS = 4,
    parameter int IDX_W   = 2,
    parameter int CNT_W   = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [WIDTH-1:0]         i_s_data,
    input  logic                     i_s_valid,
    input  logic                     i_s_last,
    output logic                     o_s_ready,
    output logic [WIDTH*NUM_OPS-1:0] o_op_bus,
    output logic                     o_start,
    input  logic                     i_done,
    output logic                     o_err,
    output logic [CNT_W-1:0]         o_frames
);

    localparam logic [IDX_W-1:0] LP_LAST_IDX = IDX_W'(NUM_OPS - 1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic               r_s_ready;
    logic               r_start;
    logic               r_err;
    logic [CNT_W-1:0]   r_frames;
    logic [WIDTH-1:0]   r_slot [NUM_OPS];

    // r_s_ready is only ever set while in LOAD, so it alone qualifies a beat.
    logic w_accept;
    assign w_accept = i_s_valid && r_s_ready;

    // -----------------------------------------------------------------------
    // Control FSM with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_LOAD;
            r_idx     <= '0;
            r_s_ready <= 1'b0;
            r_start   <= 1'b0;
            r_err     <= 1'b0;
            r_frames  <= '0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    // Ready rises on the first clock after reset release.
                    r_s_ready <= 1'b1;
                    if (w_accept) begin
                        if (r_idx == LP_LAST_IDX) begin
                            // Frame complete; a missing s_last marks a long
                            // frame, extra beats become the next frame.
                            r_idx     <= '0;
                            r_state   <= ST_ISSUE;
                            r_start   <= 1'b1;
                            r_s_ready <= 1'b0;
                            if (!i_s_last) begin
                                r_err <= 1'b1;
                            end
                        end else if (i_s_last) begin
                            // Short frame: drop it without launching.
                            r_err <= 1'b1;
                            r_idx <= '0;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                ST_ISSUE: begin
                    // i_done is deliberately ignored here.
                    r_frames  <= r_frames + CNT_W'(1);
                    r_state   <= ST_WAIT;
                    r_s_ready <= 1'b0;
                end
                ST_WAIT: begin
                    if (i_done) begin
                        r_state   <= ST_LOAD;
                        r_s_ready <= 1'b1;
                    end else begin
                        r_s_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_LOAD;
                    r_idx     <= '0;
                    r_s_ready <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Operand slots: each slot captures only the beat addressed to it, so the
    // bus is stable outside LOAD without any extra hold logic.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_slot
            logic w_slot_we;
            assign w_slot_we = w_accept && (r_idx == IDX_W'(gi));

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_slot[gi] <= '0;
                end else if (w_slot_we) begin
                    r_slot[gi] <= i_s_data;
                end
            end

            assign o_op_bus[gi*WIDTH +: WIDTH] = r_slot[gi];
        end
    endgenerate

    assign o_s_ready = r_s_ready;
    assign o_start   = r_start;
    assign o_err     = r_err;
    assign o_frames  = r_frames;

endmodule

// File: tb/tb_operand_loader.sv
module tb_operand_loader;

    localparam int WIDTH   = 32;
    localparam int NUM_OPS = 4;

    logic                     clk;
    logic                     rst_n;
    logic [WIDTH-1:0]         s_data;
    logic                     s_valid;
    logic                     s_last;
    logic                     done;

    logic                     s_ready;
    logic [WIDTH*NUM_OPS-1:0] op_bus;
    logic                     start;
    logic                     err;
    logic [15:0]              frames;

    // Second instance with a 2-bit counter sees the same stimulus.
    logic                     s_ready_w;
    logic [WIDTH*NUM_OPS-1:0] op_bus_w;
    logic                     start_w;
    logic                     err_w;
    logic [1:0]               frames_w;

    int n_checks = 0;
    int n_errors = 0;

    operand_loader #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .IDX_W(2), .CNT_W(16)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_s_data(s_data), .i_s_valid(s_valid),
        .i_s_last(s_last), .o_s_ready(s_ready), .o_op_bus(op_bus), .o_start(start),
        .i_done(done), .o_err(err), .o_frames(frames)
    );

    operand_loader #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .IDX_W(2), .CNT_W(2)) u_dut_w (
        .i_clk(clk), .i_rst_n(rst_n), .i_s_data(s_data), .i_s_valid(s_valid),
        .i_s_last(s_last), .o_s_ready(s_ready_w), .o_op_bus(op_bus_w), .o_start(start_w),
        .i_done(done), .o_err(err_w), .o_frames(frames_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        tick();
    endtask

    // From ISSUE: step into WAIT, return done in the first WAIT cycle.
    task automatic finish_frame();
        s_valid = 1'b0;
        done    = 1'b0;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        s_data  = '0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        done    = 1'b0;
        repeat (2) tick();

        // ---------------- reset state ----------------
        check("rst_ready",  s_ready, 0);
        check("rst_opbus",  op_bus, 0);
        check("rst_start",  start, 0);
        check("rst_err",    err, 0);
        check("rst_frames", frames, 0);
        $display("reset: ready=%0d op_bus=%0h err=%0d frames=%0d", s_ready, op_bus, err, frames);

        rst_n = 1'b1;
        tick();
        check("ready_after_rst", s_ready, 1);

        // ---------------- nominal frame ----------------
        send(32'h11, 1'b0);
        send(32'h22, 1'b0);
        send(32'h33, 1'b0);
        check("no_start_early", start, 0);
        send(32'h44, 1'b1);
        check("nom_start", start, 1);
        check("nom_opbus", op_bus, {32'h44, 32'h33, 32'h22, 32'h11});
        check("nom_ready_issue", s_ready, 0);
        $display("nominal: start=%0d op_bus=%0h", start, op_bus);

        // ---------------- backpressure during WAIT ----------------
        s_valid = 1'b1;
        s_data  = 32'h55;
        s_last  = 1'b0;
        tick();                                  // WAIT, cycle T+1
        check("nom_start_1cyc", start, 0);
        check("nom_frames", frames, 1);
        check("nom_err", err, 0);
        for (int i = 0; i < 4; i++) begin
            check("wait_ready", s_ready, 0);
            check("wait_opbus", op_bus, {32'h44, 32'h33, 32'h22, 32'h11});
            tick();
        end
        done = 1'b1;                             // cycle T+5
        tick();
        done = 1'b0;
        check("ready_back", s_ready, 1);
        check("opbus_held", op_bus, {32'h44, 32'h33, 32'h22, 32'h11});
        tick();                                  // 0x55 taken as slot0
        check("bp_slot0", op_bus, {32'h44, 32'h33, 32'h22, 32'h55});
        $display("backpressure: op_bus=%0h", op_bus);

        send(32'h66, 1'b0);
        send(32'h77, 1'b0);
        send(32'h88, 1'b1);
        check("f2_start", start, 1);
        check("f2_opbus", op_bus, {32'h88, 32'h77, 32'h66, 32'h55});

        // ---------------- done during ISSUE is ignored ----------------
        s_valid = 1'b0;
        done    = 1'b1;
        tick();
        done = 1'b0;
        check("f2_frames", frames, 2);
        check("issue_done_ign", s_ready, 0);
        tick();
        tick();
        check("still_wait", s_ready, 0);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("wait_exit", s_ready, 1);
        $display("done-in-issue: frames=%0d ready=%0d", frames, s_ready);

        // ---------------- short frame ----------------
        send(32'h0A, 1'b0);
        send(32'h0B, 1'b1);
        s_valid = 1'b0;
        check("short_err", err, 1);
        check("short_nostart", start, 0);
        check("short_opbus", op_bus, {32'h88, 32'h77, 32'h0B, 32'h0A});
        tick();
        check("short_nostart2", start, 0);
        send(32'h1, 1'b0);
        send(32'h2, 1'b0);
        send(32'h3, 1'b0);
        send(32'h4, 1'b1);
        check("after_short_start", start, 1);
        check("after_short_opbus", op_bus, {32'h4, 32'h3, 32'h2, 32'h1});
        finish_frame();
        check("after_short_frames", frames, 3);
        check("err_sticky", err, 1);
        $display("short frame: err=%0d frames=%0d", err, frames);

        // ---------------- reset mid-frame ----------------
        send(32'h5, 1'b0);
        send(32'h6, 1'b0);
        s_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        check("mid_rst_opbus", op_bus, 0);
        check("mid_rst_ready", s_ready, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_frames", frames, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rel_ready", s_ready, 1);
        $display("mid reset: op_bus=%0h err=%0d", op_bus, err);

        // ---------------- long frame ----------------
        send(32'h10, 1'b0);
        send(32'h20, 1'b0);
        send(32'h30, 1'b0);
        send(32'h40, 1'b0);
        check("long_start", start, 1);
        check("long_err", err, 1);
        check("long_opbus", op_bus, {32'h40, 32'h30, 32'h20, 32'h10});
        finish_frame();
        check("long_frames", frames, 1);
        $display("long frame: err=%0d frames=%0d", err, frames);

        // ---------------- counter wrap ----------------
        for (int f = 0; f < 4; f++) begin
            send(32'h100 + f, 1'b0);
            send(32'h200 + f, 1'b0);
            send(32'h300 + f, 1'b0);
            send(32'h400 + f, 1'b1);
            check("wrap_start", start, 1);
            finish_frame();
        end
        check("frames16", frames, 5);
        check("frames2_wrap", frames_w, 1);
        check("wrap_opbus", op_bus_w, {32'h403, 32'h303, 32'h203, 32'h103});
        $display("wrap: frames=%0d frames_w=%0d", frames, frames_w);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
